seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Parametrised time-multiplexed seven-segment scan controller. It is the next generation of the fixed 4-digit board display driver: digit count, scan rate and polarity are parameters, and it adds a frame-coherent data snapshot, anti-ghost blanking, leading-zero suppression, decimal points and a frame strobe. It sits at board level, clocked by the 100 MHz board clock and fed from the debug mux.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..16).
SCAN_DIV, 100_000, clk cycles per digit slot (≥ BLANK_CYCLES+2).
BLANK_CYCLES, 1_000, cycles at the start of each slot with all anodes off.
SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low to light.
AN_ACTIVE_LOW, 1, 1 = an driven low to select.

Ports:
clk  in  1  board clock
reset  in  1  synchronous, active-high reset
enable  in  1  0 = display dark, scan counters held at 0
data  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost)
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
lz_blank  in  1  1 = suppress leading zeros
seg  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
an  out  NUM_DIGITS  one-hot anode select, polarity per AN_ACTIVE_LOW
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (synchronous, active-high): prescaler=0, digit index=0, shadow data/dp=0. All outputs go to the inactive level: an all-off, seg all-off, dp off. frame_done=0.
- Prescaler counts 0..SCAN_DIV-1 while enable=1. At terminal count it wraps to 0 and the index advances. At index NUM_DIGITS-1 the index wraps to 0.
- frame_done pulses for exactly 1 cycle, in the cycle in which the index wraps NUM_DIGITS-1 → 0.
- Snapshot: the shadow register captures data, dp_in and lz_blank on that same wrap cycle, and also on the first cycle after reset or after enable rises. Digits within one frame never mix two data values.
- Digit i is lit in slot i only while prescaler ≥ BLANK_CYCLES. During the blank window, an is all-off.
- Leading-zero blanking: when lz_blank=1, digit i>0 is dark if shadow nibbles NUM_DIGITS-1..i are all zero. Digit 0 is always shown. A blanked digit still shows its dp if dp_in[i]=1.
- Decode is 0-F hex. Active-high patterns: 0=0111111, 1=0000110, …, F=1110001. Invert when SEG_ACTIVE_LOW=1.
- All outputs are registered, with 1-cycle latency from counter state to pins. an, seg and dp change in the same cycle.
- Dropping enable: on the next cycle, outputs are inactive and the prescaler and index are 0. Raising enable starts at slot 0, prescaler 0, with a fresh snapshot.
- Reset mid-frame: immediate return to reset state on the next edge. No frame_done is emitted.
- NUM_DIGITS=1: the index stays 0, and frame_done pulses every SCAN_DIV cycles.

Optional Feature:
SEG7_BRIGHTNESS_EN
- Defined: adds the input port brightness [3:0]. The digit is lit only while BLANK_CYCLES ≤ prescaler < BLANK_CYCLES + ((SCAN_DIV-BLANK_CYCLES)*(brightness+1))/16. brightness is sampled with the frame snapshot. 15 = full duty.
- Undefined: the port is absent, and behaviour equals full duty as described above.

Decomposition:
- Package seg7_pkg:
  - 16-entry active-high hex→segment constant table.
  - function apply_pol(value, active_low).
  - localparam width helper for the index: $clog2 with a floor of 1.
- Sub-module seg7_decode: combinational nibble + blank + polarity → seg[6:0]. Reusable by the legacy driver.

Test Plan:
All cases use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, both polarities = 1.
1. Reset, then enable=1, data=16'h12AF, lz_blank=0 → slots 0..3 show seg 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1). an=1110,1101,1011,0111, each low for 6 of 8 cycles. frame_done pulses every 32 cycles.
2. Change data from 16'h0000 to 16'hFFFF mid-frame (slot 2) → the rest of the frame still shows 0. The next frame shows F on all digits, starting the cycle after frame_done.
3. data=16'h0050, lz_blank=1, dp_in=4'b1000 → digits 3 and 2 dark. Digit 3 slot shows dp=0 only. Digits 1,0 show 5,0.
4. Drop enable in slot 1 → next cycle an=1111, seg=1111111, dp=1. Re-enable → slot 0 restarts and frame_done comes 32 cycles later.
5. Assert reset for 1 cycle mid-slot 3 → outputs inactive, no frame_done, scan restarts at slot 0.
6. With SEG7_BRIGHTNESS_EN and brightness=3 → each anode is low for exactly ((8-2)*4)/16=1 cycle per slot. With brightness=15 → low for 6 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller: hex segment table,
// polarity helper, index width helper and scan state encoding.
package seg7_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } scan_state_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] apply_pol(input logic [6:0] value, input logic active_low);
        return active_low ? ~value : value;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment decoder with blanking and
// selectable output polarity.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = apply_pol(blank ? 7'b0 : HEX_SEG[nibble], ACTIVE_LOW);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Parametrised time-multiplexed seven-segment scan controller with frame
// snapshot, anti-ghost blanking and leading-zero suppression.
// Optional duty-cycle dimming via SEG7_BRIGHTNESS_EN (adds brightness port).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 100_000,
    parameter int unsigned BLANK_CYCLES   = 1_000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]              brightness,
`endif
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned IDX_W   = idx_width(NUM_DIGITS);
    localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
    localparam logic [6:0]  SEG_OFF = apply_pol(7'b0, SEG_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

    scan_state_t state, state_nxt;

    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] sh_data;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_lz;

    logic                    start, slot_end, frame_end, capture;
    logic [4*NUM_DIGITS-1:0] eff_data;
    logic [NUM_DIGITS-1:0]   eff_dp;
    logic                    eff_lz;
    logic [3:0]              nib;
    logic                    dp_cur, upper_nz, dark, lit;
    logic [NUM_DIGITS-1:0]   an_on;
    logic [6:0]              dec_seg;
    int unsigned             presc_i;

`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]  sh_br;
    logic [3:0]  eff_br;
    int unsigned lit_end;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // IDLE marks "snapshot pending": entered on reset or while disabled
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable)  state_nxt = ST_RUN;
            ST_RUN:  if (!enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // On the first enabled cycle the live inputs are used directly so slot 0
    // already shows the data being captured.
    always_comb begin
        start     = (state == ST_IDLE);
        slot_end  = (presc == PRESC_W'(SCAN_DIV - 1));
        frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
        capture   = enable && (start || frame_end);
        eff_data  = start ? data     : sh_data;
        eff_dp    = start ? dp_in    : sh_dp;
        eff_lz    = start ? lz_blank : sh_lz;

        nib      = '0;
        dp_cur   = 1'b0;
        upper_nz = 1'b0;
        an_on    = AN_OFF;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (32'(idx) == j) begin
                nib      = eff_data[4*j +: 4];
                dp_cur   = eff_dp[j];
                an_on[j] = ~AN_ACTIVE_LOW;
            end
            if (j >= 32'(idx) && eff_data[4*j +: 4] != 4'h0) upper_nz = 1'b1;
        end
        dark = eff_lz && (idx != '0) && !upper_nz;

        presc_i = 32'(presc);
        lit     = (presc_i >= BLANK_CYCLES);
`ifdef SEG7_BRIGHTNESS_EN
        eff_br  = start ? brightness : sh_br;
        lit_end = BLANK_CYCLES + ((SCAN_DIV - BLANK_CYCLES) * (32'(eff_br) + 1)) / 16;
        lit     = lit && (presc_i < lit_end);
`endif
    end

    seg7_decode #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_decode (
        .nibble (nib),
        .blank  (!lit || dark),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            presc      <= '0;
            idx        <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= SEG_ACTIVE_LOW;
            frame_done <= 1'b0;
            if (reset) begin
                sh_data <= '0;
                sh_dp   <= '0;
                sh_lz   <= 1'b0;
            end
        end else begin
            presc <= slot_end ? '0 : presc + PRESC_W'(1);
            if (slot_end) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            if (capture) begin
                sh_data <= data;
                sh_dp   <= dp_in;
                sh_lz   <= lz_blank;
            end
            an         <= lit ? an_on : AN_OFF;
            seg        <= dec_seg;
            dp         <= (lit && dp_cur) ^ SEG_ACTIVE_LOW;
            frame_done <= frame_end;
        end
    end

`ifdef SEG7_BRIGHTNESS_EN
    always_ff @(posedge clk) begin
        if (reset)                  sh_br <= '0;
        else if (enable && capture) sh_br <= brightness;
    end
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
// Reference model works from elapsed enabled cycles and a frame snapshot.
module tb_seg7_scan_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned DIV = 8;
    localparam int unsigned BLK = 2;

    logic        clk = 1'b0;
    logic        reset, enable, lz_blank;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp, frame_done;
    logic [3:0]  an;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]  brightness;
`endif

    int checks = 0;
    int errors = 0;

    int unsigned k;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic        m_lz;
    logic [3:0]  m_br = 4'd15;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;

    logic [6:0] hex_pat [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data       (data),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
`ifdef SEG7_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    function automatic void take_snap();
        m_data = data;
        m_dp   = dp_in;
        m_lz   = lz_blank;
`ifdef SEG7_BRIGHTNESS_EN
        m_br   = brightness;
`endif
    endfunction

    // Advance one clock, update the model from the inputs seen at that edge,
    // and leave the expected pin values for the calling task to compare.
    task automatic step();
        int unsigned c, slot, p, lit_end;
        logic [3:0] nib;
        logic lit, dark;
        @(posedge clk);
        if (reset || !enable) begin
            k       = 0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            exp_fd  = 1'b0;
        end else begin
            k++;
            if (k == 1) take_snap();
            c       = k - 1;
            slot    = (c / DIV) % N;
            p       = c % DIV;
            lit_end = BLK + ((DIV - BLK) * (int'(m_br) + 1)) / 16;
            lit     = (p >= BLK) && (p < lit_end);
            nib     = 4'((m_data >> (4 * slot)) & 16'hF);
            dark    = m_lz && (slot > 0) && ((m_data >> (4 * slot)) == 16'h0);
            exp_an  = lit ? 4'(~(4'b0001 << slot)) : 4'hF;
            exp_seg = (lit && !dark) ? ~hex_pat[nib] : 7'h7F;
            exp_dp  = !(lit && m_dp[slot]);
            exp_fd  = (k % (DIV * N)) == 0;
            if (exp_fd) take_snap();
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; data = 16'hBEEF; dp_in = 4'hF; lz_blank = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_state: an=%b seg=%b dp=%b fd=%b, expected an=1111 seg=1111111 dp=1 fd=0",
                         an, seg, dp, frame_done);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_scan_basic();
        int an0_low = 0;
        int fd_count = 0;
        do_reset();
        data = 16'h12AF; dp_in = 4'h0; lz_blank = 1'b0; enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL scan_basic k=%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                         k, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
            end
            if (i < 32 && an == 4'b1110) an0_low++;
            if (frame_done) fd_count++;
            if (an == 4'b1101) begin
                checks++;
                if (seg !== 7'b0001000) begin
                    errors++;
                    $display("FAIL scan_digit1_A: seg=%b, expected 0001000", seg);
                end
            end
        end
        checks++;
        if (an0_low != 6) begin
            errors++;
            $display("FAIL scan_an0_duty: low cycles=%0d, expected 6", an0_low);
        end
        checks++;
        if (fd_count != 2) begin
            errors++;
            $display("FAIL scan_frame_count: pulses=%0d, expected 2", fd_count);
        end
    endtask

    task automatic test_snapshot();
        do_reset();
        data = 16'h0000; dp_in = 4'h0; lz_blank = 1'b0; enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 19) data = 16'hFFFF;
            step();
            checks++;
            if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL snapshot k=%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                         k, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
            end
            if (an != 4'hF) begin
                checks++;
                if (seg !== ((k <= 32) ? 7'b1000000 : 7'b0001110)) begin
                    errors++;
                    $display("FAIL snapshot_coherent k=%0d: seg=%b, expected %b",
                             k, seg, (k <= 32) ? 7'b1000000 : 7'b0001110);
                end
            end
        end
    endtask

    task automatic test_lz_blank();
        do_reset();
        data = 16'h0050; dp_in = 4'b1000; lz_blank = 1'b1; enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL lz_blank k=%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                         k, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
            end
            if (an == 4'b0111) begin
                checks++;
                if ({seg, dp} !== {7'h7F, 1'b0}) begin
                    errors++;
                    $display("FAIL lz_digit3_dp_only: seg=%b dp=%b, expected 1111111 0", seg, dp);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        int since = 0;
        do_reset();
        data = 16'h3C5A; dp_in = 4'b0101; lz_blank = 1'b0; enable = 1'b1;
        repeat (11) step();
        enable = 1'b0;
        step();
        checks++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL enable_drop: an=%b seg=%b dp=%b fd=%b, expected an=1111 seg=1111111 dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        enable = 1'b1;
        data = 16'h9876;
        for (int i = 0; i < 40; i++) begin
            step();
            since++;
            checks++;
            if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL enable_restart k=%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                         k, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
            end
            if (frame_done) begin
                checks++;
                if (since != 32) begin
                    errors++;
                    $display("FAIL enable_fd_latency: cycles=%0d, expected 32", since);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data = 16'h4D2E; dp_in = 4'b0010; lz_blank = 1'b0; enable = 1'b1;
        repeat (28) step();
        reset = 1'b1;
        step();
        checks++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: an=%b seg=%b dp=%b fd=%b, expected an=1111 seg=1111111 dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL reset_restart k=%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                         k, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
            end
        end
    endtask

`ifdef SEG7_BRIGHTNESS_EN
    task automatic test_brightness();
        int low;
        logic [3:0] levels [2] = '{4'd3, 4'd15};
        int want [2] = '{1, 6};
        for (int b = 0; b < 2; b++) begin
            do_reset();
            data = 16'h8888; dp_in = 4'h0; lz_blank = 1'b0; enable = 1'b1;
            brightness = levels[b];
            low = 0;
            for (int i = 0; i < 32; i++) begin
                step();
                if (an == 4'b1011) low++;
                checks++;
                if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                    errors++;
                    $display("FAIL brightness k=%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                             k, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
                end
            end
            checks++;
            if (low != want[b]) begin
                errors++;
                $display("FAIL brightness_duty level=%0d: low=%0d, expected %0d", levels[b], low, want[b]);
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) data = 16'($urandom);
            if ($urandom_range(0, 7) == 0) data = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 19) == 0) lz_blank = ~lz_blank;
`ifdef SEG7_BRIGHTNESS_EN
            if ($urandom_range(0, 19) == 0) brightness = 4'($urandom);
`endif
            enable = ($urandom_range(0, 99) != 0);
            reset  = ($urandom_range(0, 299) == 0);
            step();
            checks++;
            if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL random i=%0d k=%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                         i, k, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; data = '0; dp_in = '0; lz_blank = 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
        brightness = 4'd15;
`endif
        k = 0;
        test_reset();
        test_scan_basic();
        test_snapshot();
        test_lz_blank();
        test_enable_drop();
        test_reset_mid();
`ifdef SEG7_BRIGHTNESS_EN
        test_brightness();
        brightness = 4'd15;
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
